// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Multicycle ARM-subset sequencer with NZCV flags and condition
//            check. Define MEM_WAIT_EN to add the MemReady stall input.
// Revision : 1.0
// ============================================================================
module multicycle_controller #(
   parameter logic [3:0] CMP_CMD   = 4'b1010,
   parameter logic [3:0] SHIFT_CMD = 4'b1101
) (
   input  logic       clk,
   input  logic       reset,
`ifdef MEM_WAIT_EN
   input  logic       MemReady,
`endif
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemW,
   output logic       IRWrite,
   output logic       RegW,
   output logic [1:0] RegSrc,
   output logic [1:0] ImmSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ResultSrc,
   output logic       ShiftOp,
   output logic [3:0] Flags,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       mem_ready;
   logic [3:0] cmd;
   logic       is_cmp, is_shift, cmd_known, cond_ex;
   logic [1:0] alu_ctrl;

`ifdef MEM_WAIT_EN
   assign mem_ready = MemReady;
`else
   assign mem_ready = 1'b1;
`endif

   assign cmd      = Funct[4:1];
   assign is_cmp   = (cmd == CMP_CMD);
   assign is_shift = (cmd == SHIFT_CMD);

   always_comb begin
      alu_ctrl  = 2'b00;
      cmd_known = 1'b1;
      case (cmd)
         4'b0100:   alu_ctrl = 2'b00;
         4'b0010:   alu_ctrl = 2'b01;
         CMP_CMD:   alu_ctrl = 2'b01;
         4'b0000:   alu_ctrl = 2'b10;
         4'b1100:   alu_ctrl = 2'b11;
         SHIFT_CMD: alu_ctrl = 2'b00;
         default:   cmd_known = 1'b0;
      endcase
   end

   // Flags layout is {N, Z, C, V}
   always_comb begin
      case (Cond)
         4'b0000: cond_ex = flags_q[2];
         4'b0001: cond_ex = ~flags_q[2];
         4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
         4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      flags_d    = flags_q;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemW       = 1'b0;
      IRWrite    = 1'b0;
      RegW       = 1'b0;
      RegSrc     = 2'b00;
      ImmSrc     = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      ResultSrc  = 2'b00;
      ShiftOp    = 1'b0;
      case (state_q)
         S_FETCH: begin
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            RegSrc    = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
            if (Op == 2'b01)      ImmSrc = 2'b01;
            else if (Op == 2'b10) ImmSrc = 2'b10;
            if (!cond_ex) begin
               state_d = S_FETCH;
            end else begin
               case (Op)
                  2'b00: begin
                     if (Funct[5] || is_shift) state_d = S_EXECI;
                     else                      state_d = S_EXECR;
                  end
                  2'b01:   state_d = S_MEMADR;
                  2'b10:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR: begin
            ALUSrcB   = 2'b01;
            ImmSrc    = 2'b01;
            RegSrc[1] = ~Funct[0];
            if (Funct[0]) state_d = S_MEMRD;
            else          state_d = S_MEMWR;
         end
         S_MEMRD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b01;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = mem_ready;
            RegSrc = 2'b10;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            ALUControl = alu_ctrl;
            ShiftOp    = is_shift;
            if (Funct[0] || is_cmp) flags_d = ALUFlags;
            if (is_cmp) state_d = S_FETCH;
            else        state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegW    = cmd_known;
            ShiftOp = is_shift;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b01;
            ImmSrc    = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // An aborted instruction must not leave a partial architectural write
      if (reset) begin
         PCWrite = 1'b0;
         MemW    = 1'b0;
         IRWrite = 1'b0;
         RegW    = 1'b0;
      end
   end

   assign Flags = flags_q;
   assign State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Directed scoreboard bench for multicycle_controller.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_MEMADR = 4'd2;
   localparam logic [3:0] ST_MEMRD  = 4'd3;
   localparam logic [3:0] ST_MEMWB  = 4'd4;
   localparam logic [3:0] ST_MEMWR  = 4'd5;
   localparam logic [3:0] ST_EXECR  = 4'd6;
   localparam logic [3:0] ST_EXECI  = 4'd7;
   localparam logic [3:0] ST_ALUWB  = 4'd8;
   localparam logic [3:0] ST_BRANCH = 4'd9;

   logic       clk, reset;
   logic [3:0] Cond, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, ShiftOp;
   logic [1:0] RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
   logic [3:0] Flags, State;
`ifdef MEM_WAIT_EN
   logic       mem_ready;
`endif

   int n_err   = 0;
   int n_check = 0;
   logic [24:0] exp_q[$];
   logic [24:0] obs;

   multicycle_controller dut (
      .clk(clk), .reset(reset),
`ifdef MEM_WAIT_EN
      .MemReady(mem_ready),
`endif
      .Cond(Cond), .Op(Op), .Funct(Funct), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite),
      .RegW(RegW), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
      .ShiftOp(ShiftOp), .Flags(Flags), .State(State)
   );

   assign obs = {State, PCWrite, AdrSrc, MemW, IRWrite, RegW, RegSrc, ImmSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ShiftOp, Flags};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [24:0] ev(
      input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic rw, input logic [1:0] rs, input logic [1:0] is,
      input logic asa, input logic [1:0] asb, input logic [1:0] ac,
      input logic [1:0] res, input logic sh, input logic [3:0] fl);
      return {st, pcw, adr, mw, irw, rw, rs, is, asa, asb, ac, res, sh, fl};
   endfunction

   function automatic logic [24:0] fetch_v(input logic [3:0] fl);
      return ev(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00,
                1'b1, 2'b10, 2'b00, 2'b10, 1'b0, fl);
   endfunction

   function automatic logic [24:0] dec_v(input logic [1:0] is, input logic [1:0] rs,
                                         input logic [3:0] fl);
      return ev(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rs, is,
                1'b1, 2'b10, 2'b00, 2'b10, 1'b0, fl);
   endfunction

   // Select-only state: no enables, ALUSrcA=0, ResultSrc=00
   function automatic logic [24:0] sel_v(input logic [3:0] st, input logic adr,
      input logic mw, input logic rw, input logic [1:0] rs, input logic [1:0] is,
      input logic [1:0] asb, input logic [1:0] ac, input logic [1:0] res,
      input logic sh, input logic [3:0] fl);
      return ev(st, 1'b0, adr, mw, 1'b0, rw, rs, is, 1'b0, asb, ac, res, sh, fl);
   endfunction

   task automatic instr(input logic [3:0] c, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] af);
      Cond = c; Op = o; Funct = f; ALUFlags = af;
   endtask

   task automatic step(input string tag);
      logic [24:0] e;
      @(negedge clk);
      n_check++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n, input string tag);
      for (int k = 0; k < n; k++) step(tag);
   endtask

   initial begin
`ifdef MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      reset = 1'b1;
      instr(4'b1110, 2'b00, 6'b000000, 4'b0000);
      @(posedge clk);
      #1;
      exp_q.push_back(ev(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                         1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 4'h0));
      step("reset_hold");
      reset = 1'b0;

      // ADD R1,R2,R3 with S=0: ALUFlags must not reach Flags
      instr(4'b1110, 2'b00, 6'b001000, 4'b1111);
      exp_q.push_back(fetch_v(4'h0));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h0));
      exp_q.push_back(sel_v(ST_EXECR, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0));
      exp_q.push_back(sel_v(ST_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0));
      steps(4, "add");

      // CMP immediate writes Flags=0100
      instr(4'b1110, 2'b00, 6'b110101, 4'b0100);
      exp_q.push_back(fetch_v(4'h0));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h0));
      exp_q.push_back(sel_v(ST_EXECI, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 4'h0));
      steps(3, "cmp");

      instr(4'b0000, 2'b10, 6'b000000, 4'b0000);
      exp_q.push_back(fetch_v(4'h4));
      exp_q.push_back(dec_v(2'b10, 2'b01, 4'h4));
      exp_q.push_back(ev(ST_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                         1'b1, 2'b01, 2'b00, 2'b10, 1'b0, 4'h4));
      steps(3, "beq");

      instr(4'b0001, 2'b10, 6'b000000, 4'b0000);
      exp_q.push_back(fetch_v(4'h4));
      exp_q.push_back(dec_v(2'b10, 2'b01, 4'h4));
      steps(2, "bne_skip");

      instr(4'b1110, 2'b01, 6'b011001, 4'b0000);
      exp_q.push_back(fetch_v(4'h4));
      exp_q.push_back(dec_v(2'b01, 2'b00, 4'h4));
      exp_q.push_back(sel_v(ST_MEMADR, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 4'h4));
      exp_q.push_back(sel_v(ST_MEMRD, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h4));
      exp_q.push_back(sel_v(ST_MEMWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'h4));
      steps(5, "ldr");

      instr(4'b1110, 2'b01, 6'b011000, 4'b0000);
      exp_q.push_back(fetch_v(4'h4));
      exp_q.push_back(dec_v(2'b01, 2'b10, 4'h4));
      exp_q.push_back(sel_v(ST_MEMADR, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 4'h4));
      exp_q.push_back(sel_v(ST_MEMWR, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h4));
      steps(4, "str");

      // SUBS register: Flags=1001 visible from ALUWB on
      instr(4'b1110, 2'b00, 6'b000101, 4'b1001);
      exp_q.push_back(fetch_v(4'h4));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h4));
      exp_q.push_back(sel_v(ST_EXECR, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 4'h4));
      exp_q.push_back(sel_v(ST_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h9));
      steps(4, "subs");

      // SHIFT under GE (N=V=1): immediate path with ShiftOp held into ALUWB
      instr(4'b1010, 2'b00, 6'b011010, 4'b0000);
      exp_q.push_back(fetch_v(4'h9));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h9));
      exp_q.push_back(sel_v(ST_EXECI, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4'h9));
      exp_q.push_back(sel_v(ST_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'h9));
      steps(4, "shift_ge");

      instr(4'b1100, 2'b00, 6'b011000, 4'b0000);
      exp_q.push_back(fetch_v(4'h9));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h9));
      exp_q.push_back(sel_v(ST_EXECR, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 4'h9));
      exp_q.push_back(sel_v(ST_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h9));
      steps(4, "orr_gt");

      instr(4'b1110, 2'b00, 6'b100001, 4'b0010);
      exp_q.push_back(fetch_v(4'h9));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h9));
      exp_q.push_back(sel_v(ST_EXECI, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 4'h9));
      exp_q.push_back(sel_v(ST_ALUWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h2));
      steps(4, "ands_imm");

      // Unlisted cmd: ADD with register write suppressed
      instr(4'b1110, 2'b00, 6'b000110, 4'b1111);
      exp_q.push_back(fetch_v(4'h2));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h2));
      exp_q.push_back(sel_v(ST_EXECR, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h2));
      exp_q.push_back(sel_v(ST_ALUWB, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h2));
      steps(4, "unknown_cmd");

      instr(4'b1110, 2'b11, 6'b000000, 4'b0000);
      exp_q.push_back(fetch_v(4'h2));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h2));
      steps(2, "illegal_op");

      instr(4'b0000, 2'b00, 6'b001000, 4'b0000);
      exp_q.push_back(fetch_v(4'h2));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h2));
      steps(2, "eq_fail");

      instr(4'b0111, 2'b00, 6'b001000, 4'b0000);
      exp_q.push_back(fetch_v(4'h2));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h2));
      steps(2, "cond_unsupported");

      // Reset during MEMWR: no MemW, then FETCH with cleared flags
      instr(4'b1110, 2'b01, 6'b011000, 4'b0000);
      exp_q.push_back(fetch_v(4'h2));
      exp_q.push_back(dec_v(2'b01, 2'b10, 4'h2));
      exp_q.push_back(sel_v(ST_MEMADR, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 4'h2));
      steps(3, "str_pre_reset");
      reset = 1'b1;
      exp_q.push_back(sel_v(ST_MEMWR, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h2));
      step("memwr_reset");
      reset = 1'b0;
      instr(4'b1110, 2'b11, 6'b000000, 4'b0000);
      exp_q.push_back(fetch_v(4'h0));
      exp_q.push_back(dec_v(2'b00, 2'b00, 4'h0));
      steps(2, "after_reset");

`ifdef MEM_WAIT_EN
      instr(4'b1110, 2'b01, 6'b011001, 4'b0000);
      exp_q.push_back(fetch_v(4'h0));
      exp_q.push_back(dec_v(2'b01, 2'b00, 4'h0));
      exp_q.push_back(sel_v(ST_MEMADR, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 4'h0));
      steps(3, "ldr_wait_pre");
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++)
         exp_q.push_back(sel_v(ST_MEMRD, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0));
      steps(3, "memrd_stall");
      mem_ready = 1'b1;
      exp_q.push_back(sel_v(ST_MEMRD, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0));
      exp_q.push_back(sel_v(ST_MEMWB, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 4'h0));
      steps(2, "memrd_release");
`endif

      n_check++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL scoreboard_drain: observed=%0d expected=0 leftover", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_check);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle variant of the ARM-subset processor. It replaces the single-cycle main decoder and conditional logic with one sequencer. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives every datapath select and enable, and owns the NZCV flag register and the condition check. It sits between the instruction register and the shared datapath (single memory, single ALU, register file, PC).

Parameters:
CMP_CMD, 4'b1010, Funct[4:1] value decoded as CMP (subtract, no register write, flags always written).
SHIFT_CMD, 4'b1101, Funct[4:1] value decoded as SHIFT (register write, immediate-source operand B, ShiftOp=1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]: 00 DP, 01 MEM, 10 B, 11 illegal
Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) or L (MEM)
ALUFlags  in  4  NZCV from ALU, current cycle
PCWrite  out  1  PC load enable
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemW  out  1  memory write enable
IRWrite  out  1  instruction register load enable
RegW  out  1  register file write enable
RegSrc  out  2  [0]=PC as Rn, [1]=Rd as Rm (STR)
ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24
ALUSrcA  out  1  0=Rn reg, 1=PC
ALUSrcB  out  2  00 reg, 01 ExtImm, 10 const 4
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALU direct
ShiftOp  out  1  selects shifter output path
Flags  out  4  registered NZCV
State  out  4  current state (debug)

Behaviour:
- States (encoding 0..9): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Moore outputs per state. Every output is 0 except the ones listed for that state.
- Reset: State=FETCH, Flags=0000, all enables low during the reset cycle. Reset asserted in any state aborts the instruction on the next edge with no partial write.
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 for R15 reads). ImmSrc/RegSrc are driven from Op.
- CondEx is evaluated in DECODE against the registered Flags: 0000 EQ(Z), 0001 NE(!Z), 1010 GE(N==V), 1100 GT(!Z & N==V), 1110 AL. Any other Cond is false.
- Leaving DECODE:
  - CondEx=0 goes to FETCH.
  - Op=11 goes to FETCH; the instruction is a NOP.
  - Op=01 goes to MEMADR.
  - Op=10 goes to BRANCH.
  - Op=00 goes to EXECI if Funct[5] or cmd==SHIFT_CMD, otherwise EXECR.
- MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=00. L=1 goes to MEMRD; L=0 goes to MEMWR with RegSrc[1]=1.
- MEMRD: AdrSrc=1. Next: MEMWB. MEMWB: RegW=1, ResultSrc=01. Next: FETCH.
- MEMWR: AdrSrc=1, MemW=1, RegSrc=10. Next: FETCH.
- EXECR/EXECI: ALUSrcB 00 for EXECR, 01 for EXECI; ImmSrc=00. ALUControl is decoded from cmd:
  - 0100 gives ADD.
  - 0010 and CMP_CMD give SUB.
  - 0000 gives AND.
  - 1100 gives ORR.
  - SHIFT_CMD gives ADD with ShiftOp=1.
  - Any other cmd gives ADD with RegW suppressed in ALUWB.
- Flags <= ALUFlags at the end of the EXEC cycle when S=1 or cmd==CMP_CMD.
- From EXEC: CMP goes to FETCH; otherwise it goes to ALUWB.
- ALUWB: RegW=1, ResultSrc=00, ShiftOp held. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1. Next: FETCH.
- Latencies: DP 4 cycles, CMP 3, LDR 5, STR 4, B 3, cond-fail or illegal 2.
- Flags written in EXEC are visible to the next instruction's DECODE. There is no hazard, because at least FETCH intervenes.

Optional Feature:
- MEM_WAIT_EN defined: adds input MemReady (1 bit). FETCH, MEMRD and MEMWR hold their state and outputs while MemReady=0. PCWrite and IRWrite in FETCH, and MemW in MEMWR, are qualified by MemReady. The state advances on the first cycle with MemReady=1. Reset still overrides.
- MEM_WAIT_EN undefined: no MemReady port; memory is single-cycle, as listed above.

Test Plan:
- Reset held 2 cycles, released -> State=FETCH, Flags=0000, IRWrite=1 and PCWrite=1 in the first cycle, all other enables 0.
- ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000) -> states FETCH,DECODE,EXECR,ALUWB; RegW=1 only in ALUWB; ALUControl=00; Flags unchanged.
- CMP imm with ALUFlags=0100 in EXEC (Funct=110101), then BEQ (Cond=0000, Op=10) -> Flags=0100; branch visits BRANCH with PCWrite=1, ImmSrc=10.
- BNE immediately after the above compare -> DECODE returns to FETCH; no PCWrite in the instruction's second cycle; 2-cycle latency.
- LDR (Op=01, Funct[0]=1) then STR (Funct[0]=0) -> LDR: MEMADR,MEMRD,MEMWB with RegW=1 and ResultSrc=01 only in MEMWB. STR: MEMWR with MemW=1, AdrSrc=1, RegSrc=10.
- Reset asserted while in MEMWR, plus (MEM_WAIT_EN) MemReady=0 for 3 cycles in MEMRD -> reset: next state FETCH, no MemW on the reset edge. Stall: State stays MEMRD for 3 cycles, advances to MEMWB the cycle after MemReady=1.
